// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the multi-cycle RISC-V control path: FSM state
// enum, opcode constants, ALUOp enum, ALUControl codes and mux select codes.
// The single-cycle core reuses the ALUOp/ALUControl parts.
// Configuration macro: ILLEGAL_TRAP_EN adds the TRAP state to the state enum.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    JAL,
    BEQ
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_e;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0001;
  localparam logic [3:0] ALUC_AND = 4'b0010;
  localparam logic [3:0] ALUC_OR  = 4'b0011;
  localparam logic [3:0] ALUC_XOR = 4'b0100;
  localparam logic [3:0] ALUC_SLT = 4'b0101;
  localparam logic [3:0] ALUC_SLL = 4'b0110;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, so it is decoded the same
  // way in every FSM state.
  function automatic logic [1:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// multi_cycle_controller_if
// Bundles the instruction fields, memory handshake and datapath control
// strobes between the controller and the datapath.
//   master: datapath side (drives op/funct3/funct7b5/Zero/MemReady)
//   slave : controller side (drives all control outputs)
interface multi_cycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       AdrSrc;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Trap;

  modport master (
    output op, funct3, funct7b5, Zero, MemReady,
    input  MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap
  );

  modport slave (
    input  op, funct3, funct7b5, Zero, MemReady,
    output MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap
  );
endinterface

// File: rtl/multi_cycle_controller_alu_decoder.sv
// alu_decoder
// Combinational map from ALUOp plus instruction fields to ALUControl.
// Ports:
//   aluOp_i      : add / sub / decode-from-funct request from the main FSM
//   funct3_i     : instr[14:12]
//   funct7b5_i   : instr[30]
//   opb5_i       : op[5], separates R-type (1) from I-ALU (0)
//   aluControl_o : ALU operation code
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_e     aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       opb5_i,
  output logic [3:0] aluControl_o
);

  // funct3 000 is only a subtract for R-type; addi reuses instr[30] as an
  // immediate bit, hence the op[5] qualifier.
  always_comb begin
    aluControl_o = ALUC_ADD;
    case (aluOp_i)
      ALUOP_ADD: aluControl_o = ALUC_ADD;
      ALUOP_SUB: aluControl_o = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  aluControl_o = (opb5_i & funct7b5_i) ? ALUC_SUB : ALUC_ADD;
          3'b001:  aluControl_o = ALUC_SLL;
          3'b010:  aluControl_o = ALUC_SLT;
          3'b011:  aluControl_o = ALUC_ADD;
          3'b100:  aluControl_o = ALUC_XOR;
          3'b101:  aluControl_o = funct7b5_i ? ALUC_SRA : ALUC_SRL;
          3'b110:  aluControl_o = ALUC_OR;
          default: aluControl_o = ALUC_AND;
        endcase
      end
      default: aluControl_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
// Moore-style main FSM sequencing the multi-cycle RISC-V datapath through
// fetch, decode, execute, memory and writeback, with a MemReady wait-state
// handshake on the shared memory port.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset; holds the FSM in FETCH with all
//           write strobes and Trap forced low
//   bus   : slave side of multi_cycle_controller_if (instruction fields,
//           Zero, MemReady in; all control selects and strobes out)
// Configuration macro: ILLEGAL_TRAP_EN -- when defined, an illegal opcode
// parks the FSM in TRAP (Trap=1) until reset; otherwise it is a no-op.
module multi_cycle_controller
  import riscv_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  multi_cycle_controller_if.slave        bus
);

  state_e     state_q, state_d;
  aluop_e     aluOp;
  logic [3:0] aluControl;
  logic       memReq, memWrite, irWrite, pcWrite, adrSrc, regWrite, trap;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;

  // Reset lands in FETCH straight away so the FETCH selects appear on the
  // outputs before any clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // MemReady only matters in the three states that own the memory port.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.MemReady) state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECR;
          OP_IALU:      state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.MemReady) state_d = MEMWB;
      MEMWRITE: if (bus.MemReady) state_d = FETCH;
      EXECR, EXECI, JAL: state_d = ALUWB;
      MEMWB, ALUWB, BEQ: state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:     state_d = TRAP;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Per-state control word. Everything defaults to 0 so unused selects are
  // driven low; the memory-completing strobes follow MemReady so a stalled
  // access never writes early.
  always_comb begin
    memReq    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    regWrite  = 1'b0;
    trap      = 1'b0;
    resultSrc = RES_ALUOUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RS2;
    aluOp     = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        memReq    = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        irWrite   = bus.MemReady;
        pcWrite   = bus.MemReady;
      end
      DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
      end
      EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
      end
      MEMREAD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
      end
      MEMWRITE: begin
        memReq   = 1'b1;
        adrSrc   = 1'b1;
        memWrite = bus.MemReady;
      end
      MEMWB: begin
        resultSrc = RES_MEMDATA;
        regWrite  = 1'b1;
      end
      ALUWB: regWrite = 1'b1;
      EXECR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        aluOp   = ALUOP_FUNCT;
      end
      JAL: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
        pcWrite = 1'b1;
      end
      BEQ: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        aluOp   = ALUOP_SUB;
        pcWrite = bus.Zero;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluOp_i      (aluOp),
    .funct3_i     (bus.funct3),
    .funct7b5_i   (bus.funct7b5),
    .opb5_i       (bus.op[5]),
    .aluControl_o (aluControl)
  );

  // The state is already FETCH during reset, but FETCH's IRWrite/PCWrite
  // follow MemReady, so the strobes are gated with rst_n explicitly.
  assign bus.MemReq     = memReq;
  assign bus.AdrSrc     = adrSrc;
  assign bus.ResultSrc  = resultSrc;
  assign bus.ALUSrcA    = aluSrcA;
  assign bus.ALUSrcB    = aluSrcB;
  assign bus.ALUControl = aluControl;
  assign bus.ImmSrc     = immSrcFor(bus.op);
  assign bus.MemWrite   = memWrite & rst_n;
  assign bus.IRWrite    = irWrite  & rst_n;
  assign bus.PCWrite    = pcWrite  & rst_n;
  assign bus.RegWrite   = regWrite & rst_n;
  assign bus.Trap       = trap     & rst_n;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller
// Self-checking bench for multi_cycle_controller. Each instruction is
// expanded into the list of steps it should walk through; memory steps are
// repeated while MemReady is low. Every cycle the full control word is
// compared against the word the step should produce.
// Configuration macro: ILLEGAL_TRAP_EN (bench follows the same build option).
module tb_multi_cycle_controller;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] BQ = 7'b1100011;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ, P_TRAP
  } phase_e;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   writePulses = 0;

  multi_cycle_controller_if bus();

  multi_cycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [18:0] obs;
  assign obs = {bus.MemReq, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                bus.AdrSrc, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.Trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
  endfunction

  // ALU code requested by funct3 when the FSM asks for funct decoding.
  function automatic logic [3:0] functCode(input logic [2:0] f3, input logic f7, input logic opb5);
    logic [3:0] table8 [8];
    logic [3:0] code;
    table8 = '{4'd0, 4'd6, 4'd5, 4'd0, 4'd4, 4'd7, 4'd3, 4'd2};
    code = table8[f3];
    if (f3 == 3'd0 && opb5 && f7) code = 4'd1;
    if (f3 == 3'd5 && f7)         code = 4'd8;
    return code;
  endfunction

  // Control word a step should show, packed in the same order as obs.
  function automatic logic [18:0] expBundle(input phase_e ph, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z, input logic rdy, input logic inRst);
    logic memReq, memWr, irWr, pcWr, adr, regWr, trp;
    logic [1:0] res, srcA, srcB, imm;
    logic [3:0] aluc;
    {memReq, memWr, irWr, pcWr, adr, regWr, trp} = '0;
    res = 2'b00; srcA = 2'b00; srcB = 2'b00; aluc = 4'd0;
    imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    case (ph)
      P_FETCH:    begin memReq = 1; srcB = 2'b10; res = 2'b10; irWr = rdy; pcWr = rdy; end
      P_DECODE:   begin srcA = 2'b01; srcB = 2'b01; end
      P_MEMADR:   begin srcA = 2'b10; srcB = 2'b01; end
      P_EXECI:    begin srcA = 2'b10; srcB = 2'b01; aluc = functCode(f3, f7, o[5]); end
      P_MEMREAD:  begin memReq = 1; adr = 1; end
      P_MEMWRITE: begin memReq = 1; adr = 1; memWr = rdy; end
      P_MEMWB:    begin res = 2'b01; regWr = 1; end
      P_ALUWB:    regWr = 1;
      P_EXECR:    begin srcA = 2'b10; aluc = functCode(f3, f7, o[5]); end
      P_JAL:      begin srcA = 2'b01; srcB = 2'b10; pcWr = 1; end
      P_BEQ:      begin srcA = 2'b10; aluc = 4'd1; pcWr = z; end
      P_TRAP:     trp = 1;
      default: ;
    endcase
    if (inRst) {memWr, irWr, pcWr, regWr, trp} = '0;
    return {memReq, memWr, irWr, pcWr, adr, regWr, res, srcA, srcB, imm, aluc, trp};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (op=%b f3=%b f7b5=%b)",
               tag, got, exp, bus.op, bus.funct3, bus.funct7b5);
    end
  endtask

  // One cycle: drive MemReady/Zero just after the edge, check mid-cycle,
  // then move on to just after the next rising edge.
  task automatic applyStimulus(input phase_e ph, input logic rdy, input logic z);
    bus.MemReady = rdy;
    bus.Zero     = z;
    @(negedge clk);
    checkOutput(ph.name(), 32'(obs),
                32'(expBundle(ph, bus.op, bus.funct3, bus.funct7b5, z, rdy, 1'b0)));
    if (bus.MemWrite) writePulses++;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle and checks the forced FETCH word both before
  // and after a clock edge, then releases just after an edge.
  task automatic resetCheck();
    rst_n = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    checkOutput("resetAsync", 32'(obs),
                32'(expBundle(P_FETCH, bus.op, bus.funct3, bus.funct7b5, bus.Zero, 1'b1, 1'b1)));
    @(posedge clk);
    #1;
    checkOutput("resetHeld", 32'(obs),
                32'(expBundle(P_FETCH, bus.op, bus.funct3, bus.funct7b5, bus.Zero, 1'b1, 1'b1)));
    rst_n = 1'b1;
  endtask

  // zeroMode: 0/1 fixed Zero value, 2 random per cycle.
  task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input int zeroMode, input bit randomReady, input int stalls);
    phase_e steps[$];
    phase_e ph;
    int     stallLeft;
    int     zeros;
    logic   r, z;
    stallLeft = stalls;
    zeros = 0;
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    writePulses = 0;
    steps = {P_FETCH, P_DECODE};
    case (o)
      LW: begin steps.push_back(P_MEMADR); steps.push_back(P_MEMREAD); steps.push_back(P_MEMWB); end
      SW: begin steps.push_back(P_MEMADR); steps.push_back(P_MEMWRITE); end
      RT: begin steps.push_back(P_EXECR); steps.push_back(P_ALUWB); end
      IT: begin steps.push_back(P_EXECI); steps.push_back(P_ALUWB); end
      JL: begin steps.push_back(P_JAL); steps.push_back(P_ALUWB); end
      BQ: steps.push_back(P_BEQ);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) steps.push_back(P_TRAP);
`endif
      end
    endcase
    while (steps.size() != 0) begin
      ph = steps[0];
      if (randomReady)
        r = (zeros >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else if ((ph == P_MEMREAD || ph == P_MEMWRITE) && stallLeft > 0) begin
        r = 1'b0;
        stallLeft--;
      end else
        r = 1'b1;
      zeros = r ? 0 : zeros + 1;
      z = (zeroMode == 2) ? 1'($urandom_range(0, 1)) : (zeroMode == 1);
      applyStimulus(ph, r, z);
      if (r || !(ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE))
        void'(steps.pop_front());
    end
    checkOutput("memWritePulses", 32'(writePulses), (o == SW) ? 32'd1 : 32'd0);
`ifdef ILLEGAL_TRAP_EN
    if (!isLegal(o)) resetCheck();
`endif
  endtask

  // Walks lw into MEMREAD, stalls it, and pulls reset mid-access.
  task automatic resetMidRead();
    bus.op = LW;
    bus.funct3 = 3'b010;
    bus.funct7b5 = 1'b0;
    applyStimulus(P_FETCH, 1'b1, 1'b0);
    applyStimulus(P_DECODE, 1'b1, 1'b0);
    applyStimulus(P_MEMADR, 1'b1, 1'b0);
    bus.MemReady = 1'b0;
    #1;
    checkOutput("memReadBeforeReset", 32'(obs),
                32'(expBundle(P_MEMREAD, LW, 3'b010, 1'b0, bus.Zero, 1'b0, 1'b0)));
    resetCheck();
  endtask

  initial begin
    logic [6:0] rop;
    int         kind;
    rst_n = 1'b1;
    bus.op = IT;
    bus.funct3 = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    resetCheck();

    runInstr(LW, 3'b010, 1'b0, 0, 1'b0, 0);
    runInstr(SW, 3'b010, 1'b0, 0, 1'b0, 2);
    runInstr(RT, 3'b000, 1'b1, 0, 1'b0, 0);
    runInstr(IT, 3'b000, 1'b1, 0, 1'b0, 0);
    runInstr(RT, 3'b101, 1'b1, 0, 1'b0, 0);
    runInstr(IT, 3'b101, 1'b0, 0, 1'b0, 0);
    runInstr(BQ, 3'b000, 1'b0, 1, 1'b0, 0);
    runInstr(BQ, 3'b000, 1'b0, 0, 1'b0, 0);
    runInstr(JL, 3'b000, 1'b0, 0, 1'b0, 0);
    runInstr(7'b1111111, 3'b000, 1'b0, 0, 1'b0, 0);
    runInstr(LW, 3'b010, 1'b0, 0, 1'b0, 3);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = JL;
        5: rop = BQ;
        default: begin
          rop = 7'($urandom_range(0, 127));
          while (isLegal(rop)) rop = 7'($urandom_range(0, 127));
        end
      endcase
      runInstr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, 1'b1, 0);
    end

    resetMidRead();
    runInstr(LW, 3'b010, 1'b0, 0, 1'b0, 0);
    runInstr(RT, 3'b111, 1'b0, 2, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
